pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32 core. It merges the hazard unit's stall and branch-flush requests with multi-cycle resource waits: D-cache miss in M, I-cache miss in F, and the iterative mul/div unit in E. It produces per-stage register enables and bubble-insert (flush) controls. It also keeps saturating stall and flush performance counters.

Parameters:
MD_LAT, 4, mul/div latency in cycles from accepted start to result available; legal range ≥1; value 1 means no freeze.
CNT_W, 32, width of each performance counter.

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
hz_stall  in  1  load-use / branch-operand stall from hazard unit (stage D)
mispredict  in  1  branch/jump resolved wrong in E
imem_busy  in  1  I-cache miss, F instruction not valid
dmem_busy  in  1  D-cache miss, M access incomplete
md_start  in  1  mul/div instruction present in E
md_issue  out  1  one-cycle pulse: mul/div start accepted
en_F  out  1  PC / F-D register enable
en_D  out  1  D-E register enable
en_E  out  1  E-M register enable
en_M  out  1  M-W register enable
flush_D  out  1  insert bubble into D-E register
flush_E  out  1  insert bubble into E-M register
flush_M  out  1  insert bubble into M-W register
stall_cnt  out  CNT_W  cycles with en_F=0
flush_cnt  out  CNT_W  mispredict flushes applied

Behaviour:
- Only one clock domain. Reset is asynchronous and active-low via rst_n.
- While rst_n=0: state=RUN, md counter=0, both perf counters=0, md_issue=0, all en_*=0, all flush_*=1.
- FSM states:
  - RUN: normal operation.
  - MD_WAIT: mul/div in flight. Holds a down-counter md_cnt of width clog2(MD_LAT).
- Each cycle, the enables and flushes come from the first matching rule (strict priority). Controls not named in a rule are en=1 and flush=0.
  - P1, dmem_busy=1: en_F=en_D=en_E=en_M=0, flush_M=1 (bubble into W).
  - P2, md freeze: en_F=en_D=en_E=0, flush_M=1. Applies in either case:
    - RUN with md_start=1 and MD_LAT>1;
    - MD_WAIT with md_cnt≠0.
  - P3, mispredict=1: flush_D=1, flush_E=1, en_F=1 (PC redirect wins over imem_busy).
  - P4, hz_stall=1: en_F=en_D=0, flush_D=1.
  - P5, imem_busy=1: en_F=0, flush_D... not used; instead en_F=0 with the F-D register bubble handled as en_D=1 and flush_D=1.
  - Otherwise all enables are 1 and all flushes are 0.
- RUN → MD_WAIT: when md_start=1, dmem_busy=0 and MD_LAT>1. In that cycle md_issue=1 and md_cnt←MD_LAT-2.
- MD_WAIT, dmem_busy=0:
  - md_cnt≠0: md_cnt decrements.
  - md_cnt=0: release cycle. E advances and state→RUN. md_start is ignored in this cycle, so there is no re-issue.
- MD_WAIT, dmem_busy=1: md_cnt still decrements but does not go below 0. State does not leave MD_WAIT until a release cycle occurs with dmem_busy=0.
- E-stage occupancy of a mul/div is exactly MD_LAT cycles when there are no dmem stalls.
- MD_LAT=1: md_start is ignored, md_issue stays 0, and the FSM never leaves RUN.
- md_start and dmem_busy together in RUN: no issue. md_start is re-evaluated in the next cycle.
- mispredict during P1/P2: not applied. E is frozen, so the request persists and is applied once released.
- stall_cnt increments on every cycle with en_F=0 after reset. It saturates at all-ones.
- flush_cnt increments on each cycle where P3 is selected. It saturates at all-ones.
- All outputs are combinational from state, md_cnt and inputs. md_issue is also combinational. Latency is 0 cycles from input to control.

Decomposition:
- pipeline_pkg holds:
  - typedef enum logic {RUN, MD_WAIT} pctrl_state_t;
  - the priority-rule encoding constants.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
1. Reset deasserted with no requests → en_F..en_M=1, flushes=0, counters=0. Assert rst_n=0 mid-MD_WAIT → state RUN and counters 0 immediately, without waiting for a clock.
2. hz_stall pulsed for 1 cycle → en_F=en_D=0 and flush_D=1 for exactly that cycle; stall_cnt=1.
3. MD_LAT=4, md_start held → md_issue pulses once; en_E=0 for 3 cycles then 1 for 1 cycle; state back in RUN; no second md_issue.
4. MD_LAT=4, dmem_busy asserted on the release cycle for 5 cycles → state stays MD_WAIT with md_cnt=0; release happens the cycle after dmem_busy falls; md_issue total =1.
5. mispredict with imem_busy and hz_stall all =1 → flush_D=flush_E=1, en_F=1; flush_cnt increments by 1.
6. mispredict while dmem_busy=1 for 3 cycles → no flush during the miss; flush applied on the first cycle after dmem_busy=0. Force stall_cnt near its limit (CNT_W=4, 20 stalls) → stall_cnt=15 and it holds.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the RV32 pipeline sequencing controller: FSM state,
// priority-rule codes and the per-rule stage control pattern.
package pipeline_pkg;

    typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} pctrl_state_t;

    localparam logic [2:0] RULE_NONE = 3'd0;
    localparam logic [2:0] RULE_DMEM = 3'd1;
    localparam logic [2:0] RULE_MD   = 3'd2;
    localparam logic [2:0] RULE_MISP = 3'd3;
    localparam logic [2:0] RULE_HZ   = 3'd4;
    localparam logic [2:0] RULE_IMEM = 3'd5;

    typedef struct packed {
        logic en_f;
        logic en_d;
        logic en_e;
        logic en_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
    } pctrl_ctrl_t;

    // Unknown rule codes fall back to a fully frozen, bubbling pipeline.
    function automatic pctrl_ctrl_t rule_ctrl(input logic [2:0] rule);
        pctrl_ctrl_t c;
        case (rule)
            RULE_DMEM: c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            RULE_MD:   c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            RULE_MISP: c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            RULE_HZ:   c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            RULE_IMEM: c = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            RULE_NONE: c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            default:   c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/control bundle between the core datapath (master) and the
// pipeline sequencing controller (slave).
interface pipeline_ctrl_if;
    logic hz_stall;
    logic mispredict;
    logic imem_busy;
    logic dmem_busy;
    logic md_start;
    logic md_issue;
    logic en_F;
    logic en_D;
    logic en_E;
    logic en_M;
    logic flush_D;
    logic flush_E;
    logic flush_M;

    modport master (
        output hz_stall, mispredict, imem_busy, dmem_busy, md_start,
        input  md_issue, en_F, en_D, en_E, en_M, flush_D, flush_E, flush_M
    );

    modport slave (
        input  hz_stall, mispredict, imem_busy, dmem_busy, md_start,
        output md_issue, en_F, en_D, en_E, en_M, flush_D, flush_E, flush_M
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualified cycles, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1'b1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: merges hazard, mispredict, cache-miss and
// mul/div waits into per-stage enables/bubbles, with perf counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.slave   bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MDC_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [MDC_W-1:0] MDC_INIT = MDC_W'((MD_LAT > 1) ? (MD_LAT - 2) : 0);
    localparam logic MD_EN = (MD_LAT > 1) ? 1'b1 : 1'b0;

    pctrl_state_t     state_r;
    logic [MDC_W-1:0] md_cnt_r;
    logic             md_freeze_s;
    logic             issue_s;
    logic [2:0]       rule_s;
    pctrl_ctrl_t      ctrl_s;

    // Mul/div freeze and issue decode; md_start is ignored outside RUN.
    always_comb begin
        md_freeze_s = 1'b0;
        issue_s     = 1'b0;
        if (state_r == RUN) begin
            md_freeze_s = MD_EN & bus.md_start;
            issue_s     = MD_EN & bus.md_start & ~bus.dmem_busy;
        end else begin
            md_freeze_s = (md_cnt_r != {MDC_W{1'b0}});
            issue_s     = 1'b0;
        end
    end

    // Strict-priority rule selection.
    always_comb begin
        rule_s = RULE_NONE;
        if (bus.dmem_busy) begin
            rule_s = RULE_DMEM;
        end else if (md_freeze_s) begin
            rule_s = RULE_MD;
        end else if (bus.mispredict) begin
            rule_s = RULE_MISP;
        end else if (bus.hz_stall) begin
            rule_s = RULE_HZ;
        end else if (bus.imem_busy) begin
            rule_s = RULE_IMEM;
        end else begin
            rule_s = RULE_NONE;
        end
    end

    assign ctrl_s = rule_ctrl(rule_s);

    // Drive stage controls; reset freezes every stage and bubbles all registers.
    always_comb begin
        if (!rst_n) begin
            bus.md_issue = 1'b0;
            bus.en_F     = 1'b0;
            bus.en_D     = 1'b0;
            bus.en_E     = 1'b0;
            bus.en_M     = 1'b0;
            bus.flush_D  = 1'b1;
            bus.flush_E  = 1'b1;
            bus.flush_M  = 1'b1;
        end else begin
            bus.md_issue = issue_s;
            bus.en_F     = ctrl_s.en_f;
            bus.en_D     = ctrl_s.en_d;
            bus.en_E     = ctrl_s.en_e;
            bus.en_M     = ctrl_s.en_m;
            bus.flush_D  = ctrl_s.flush_d;
            bus.flush_E  = ctrl_s.flush_e;
            bus.flush_M  = ctrl_s.flush_m;
        end
    end

    // Mul/div FSM: md_cnt keeps counting under dmem stalls, release waits for dmem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= RUN;
            md_cnt_r <= {MDC_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (issue_s) begin
                        state_r  <= MD_WAIT;
                        md_cnt_r <= MDC_INIT;
                    end else begin
                        state_r  <= RUN;
                        md_cnt_r <= {MDC_W{1'b0}};
                    end
                end
                MD_WAIT: begin
                    if (md_cnt_r != {MDC_W{1'b0}}) begin
                        md_cnt_r <= md_cnt_r - MDC_W'(1'b1);
                    end else if (!bus.dmem_busy) begin
                        state_r  <= RUN;
                    end else begin
                        state_r  <= MD_WAIT;
                    end
                end
                default: begin
                    state_r  <= RUN;
                    md_cnt_r <= {MDC_W{1'b0}};
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~ctrl_s.en_f),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rule_s == RULE_MISP),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then random
// traffic, compared against a cycle-age reference model.
module tb_pipeline_ctrl;
    import pipeline_pkg::*;

    localparam int LAT  = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus ();
    pipeline_ctrl_if bus1 ();
    logic [CW-1:0] stall_cnt, flush_cnt, stall_cnt1, flush_cnt1;

    pipeline_ctrl #(.MD_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.MD_LAT(1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    assign bus1.hz_stall   = bus.hz_stall;
    assign bus1.mispredict = bus.mispredict;
    assign bus1.imem_busy  = bus.imem_busy;
    assign bus1.dmem_busy  = bus.dmem_busy;
    assign bus1.md_start   = bus.md_start;

    int n_vec = 0;
    int n_err = 0;
    bit m_busy = 1'b0;
    int m_age = 0;
    int m_stall = 0;
    int m_flush = 0;

    localparam logic [7:0] RESET_VEC = 8'b0_0000_111;

    // Expected {md_issue, en_F, en_D, en_E, en_M, flush_D, flush_E, flush_M}.
    function automatic logic [7:0] model_ctrl(input int lat, input bit busy, input int age,
                                              input bit hz, input bit mis, input bit im,
                                              input bit dm, input bit ms);
        bit freeze;
        bit issue;
        logic [6:0] c;
        freeze = busy ? (age < lat - 1) : (ms && lat > 1);
        issue  = !busy && ms && !dm && lat > 1;
        if (dm)          c = 7'b0000_001;
        else if (freeze) c = 7'b0001_001;
        else if (mis)    c = 7'b1111_110;
        else if (hz)     c = 7'b0011_100;
        else if (im)     c = 7'b0111_100;
        else             c = 7'b1111_000;
        return {issue, c};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {bus.md_issue, bus.en_F, bus.en_D, bus.en_E, bus.en_M,
                bus.flush_D, bus.flush_E, bus.flush_M};
    endfunction

    function automatic logic [7:0] dut1_vec();
        return {bus1.md_issue, bus1.en_F, bus1.en_D, bus1.en_E, bus1.en_M,
                bus1.flush_D, bus1.flush_E, bus1.flush_M};
    endfunction

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic checkn(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_age   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // One clock: drive, check controls mid-cycle, then advance the model.
    task automatic step(input bit hz, input bit mis, input bit im, input bit dm,
                        input bit ms, input string tag);
        logic [7:0] exp;
        bus.hz_stall   = hz;
        bus.mispredict = mis;
        bus.imem_busy  = im;
        bus.dmem_busy  = dm;
        bus.md_start   = ms;
        #4;
        exp = model_ctrl(LAT, m_busy, m_age, hz, mis, im, dm, ms);
        check8({tag, "_ctrl"}, dut_vec(), exp);
        check8({tag, "_ctrl_lat1"}, dut1_vec(), model_ctrl(1, 1'b0, 0, hz, mis, im, dm, ms));
        checkn({tag, "_stall_cnt"}, int'(stall_cnt), m_stall);
        checkn({tag, "_flush_cnt"}, int'(flush_cnt), m_flush);
        @(posedge clk);
        if (!exp[6] && m_stall < MAXC) m_stall++;
        if (exp[6:0] == 7'b1111_110 && m_flush < MAXC) m_flush++;
        if (!m_busy) begin
            if (exp[7]) begin
                m_busy = 1'b1;
                m_age  = 1;
            end
        end else if (m_age >= LAT - 1 && !dm) begin
            m_busy = 1'b0;
        end else begin
            m_age++;
        end
        #1;
    endtask

    task automatic check_reset(input string tag);
        check8({tag, "_rst_ctrl"}, dut_vec(), RESET_VEC);
        checkn({tag, "_rst_stall"}, int'(stall_cnt), 0);
        checkn({tag, "_rst_flush"}, int'(flush_cnt), 0);
        checkn({tag, "_rst_state"}, int'(dut.state_r === RUN), 1);
    endtask

    initial begin
        bus.hz_stall   = 1'b0;
        bus.mispredict = 1'b0;
        bus.imem_busy  = 1'b0;
        bus.dmem_busy  = 1'b0;
        bus.md_start   = 1'b0;
        model_reset();
        #2;
        check_reset("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step(0, 0, 0, 0, 0, "idle0");
        step(0, 0, 0, 0, 0, "idle1");

        step(1, 0, 0, 0, 0, "hz_pulse");
        step(0, 0, 0, 0, 0, "hz_after");

        // mul/div with md_start held through the release cycle
        for (int i = 0; i < LAT; i++) step(0, 0, 0, 0, 1, "md_held");
        step(0, 0, 0, 0, 0, "md_done");

        // dmem miss landing on the release cycle
        for (int i = 0; i < LAT - 1; i++) step(0, 0, 0, 0, 1, "md_pre");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, "md_dmem");
        step(0, 0, 0, 0, 1, "md_release");
        step(0, 0, 0, 0, 0, "md_post");

        step(1, 1, 1, 0, 0, "misp_all");
        step(0, 0, 0, 0, 0, "misp_after");

        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, "misp_dmem");
        step(0, 1, 0, 0, 0, "misp_apply");
        step(0, 0, 0, 0, 0, "misp_done");

        // md_start together with dmem_busy in RUN must not issue
        step(0, 0, 0, 1, 1, "md_blocked");
        step(0, 0, 0, 0, 1, "md_retry");
        step(0, 0, 0, 0, 0, "md_mid");

        // asynchronous reset in the middle of MD_WAIT
        bus.md_start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("mid_md");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, "post_rst");

        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, "sat_fill");
        step(0, 0, 0, 0, 0, "sat_hold");
        checkn("sat_stall_max", int'(stall_cnt), MAXC);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 25, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
